// File: rtl/cpu_run_ctrl_if.sv
// Run-controller bundle: host start/mode/step, CPU halt/retire, and the
// controller's CPU reset/enable plus run status and counters.
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             mode;
    logic             step;
    logic             halt;
    logic             retire;
    logic             cpu_reset;
    logic             cpu_en;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    // master: the run controller
    modport master (
        input  start, mode, step, halt, retire,
        output cpu_reset, cpu_en, busy, done, timeout, cycle_cnt, retire_cnt
    );

    // slave: host and CPU side
    modport slave (
        output start, mode, step, halt, retire,
        input  cpu_reset, cpu_en, busy, done, timeout, cycle_cnt, retire_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: reset sequencing, free-run/single-step enable, cycle limit.
// Define CPU_RUN_CTRL_RETIRE_EN to build the retired-instruction counter.
module cpu_run_ctrl #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned MAX_CYCLES = 100,
    parameter int unsigned CNT_W      = 32
) (
    input  logic           clk,
    input  logic           reset,
    cpu_run_ctrl_if.master bus
);
    typedef enum logic [1:0] {StIdle, StRst, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] CntAll  = '1;
    localparam logic [CNT_W-1:0] Limit   = CNT_W'(MAX_CYCLES);
    localparam logic [7:0]       RstLoad = 8'(RST_CYCLES - 1);

    state_e           r_state, w_state_nxt;
    logic [7:0]       r_rst_cnt, w_rst_cnt_nxt;
    logic             r_mode, w_mode_nxt;
    logic [CNT_W-1:0] r_cycle_cnt, w_cycle_cnt_nxt, w_cyc_inc;
    logic             r_cpu_reset, r_cpu_en, w_cpu_en_nxt;
    logic             r_busy, r_done, w_done_nxt, r_timeout, w_timeout_nxt;
    logic             w_start_ok;

    assign w_start_ok = bus.start && (r_state == StIdle || r_state == StDone);
    assign w_cyc_inc  = (r_cycle_cnt == CntAll) ? r_cycle_cnt : r_cycle_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_rst_cnt_nxt   = r_rst_cnt;
        w_mode_nxt      = r_mode;
        w_cycle_cnt_nxt = r_cycle_cnt;
        w_cpu_en_nxt    = 1'b0;
        w_done_nxt      = r_done;
        w_timeout_nxt   = r_timeout;
        unique case (r_state)
            StIdle, StDone: begin
                if (w_start_ok) begin
                    w_state_nxt     = StRst;
                    w_rst_cnt_nxt   = RstLoad;
                    w_mode_nxt      = bus.mode;
                    w_cycle_cnt_nxt = '0;
                    w_done_nxt      = 1'b0;
                    w_timeout_nxt   = 1'b0;
                end
            end
            StRst: begin
                if (r_rst_cnt == 8'd0) begin
                    w_state_nxt  = StRun;
                    w_cpu_en_nxt = !r_mode;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt - 8'd1;
                end
            end
            StRun: begin
                if (r_cpu_en) w_cycle_cnt_nxt = w_cyc_inc;
                // Halt takes priority over the cycle limit landing on the same edge
                if (bus.halt) begin
                    w_state_nxt = StDone;
                    w_done_nxt  = 1'b1;
                end else if (MAX_CYCLES != 0 && r_cpu_en && w_cyc_inc == Limit) begin
                    w_state_nxt   = StDone;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cpu_en_nxt = r_mode ? bus.step : 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_rst_cnt   <= 8'd0;
            r_mode      <= 1'b0;
            r_cycle_cnt <= '0;
            r_cpu_reset <= 1'b1;
            r_cpu_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_mode      <= w_mode_nxt;
            r_cycle_cnt <= w_cycle_cnt_nxt;
            r_cpu_reset <= (w_state_nxt == StIdle) || (w_state_nxt == StRst);
            r_cpu_en    <= w_cpu_en_nxt;
            r_busy      <= (w_state_nxt == StRst) || (w_state_nxt == StRun);
            r_done      <= w_done_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

`ifdef CPU_RUN_CTRL_RETIRE_EN
    logic [CNT_W-1:0] r_retire_cnt, w_retire_cnt_nxt;

    always_comb begin
        w_retire_cnt_nxt = r_retire_cnt;
        if (w_start_ok) begin
            w_retire_cnt_nxt = '0;
        end else if (r_state == StRun && bus.retire && r_retire_cnt != CntAll) begin
            w_retire_cnt_nxt = r_retire_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_retire_cnt <= '0;
        else       r_retire_cnt <= w_retire_cnt_nxt;
    end

    assign bus.retire_cnt = r_retire_cnt;
`else
    logic w_unused_retire;
    assign w_unused_retire = bus.retire;
    assign bus.retire_cnt  = '0;
`endif

    assign bus.cpu_reset = r_cpu_reset;
    assign bus.cpu_en    = r_cpu_en;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.timeout   = r_timeout;
    assign bus.cycle_cnt = r_cycle_cnt;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized bench for cpu_run_ctrl against a run-level reference model.
// Honours CPU_RUN_CTRL_RETIRE_EN the same way the design does.
module tb_cpu_run_ctrl;
    localparam int unsigned RstCycles = 4;
    localparam int unsigned MaxCycles = 100;
    localparam int unsigned CntW      = 32;
`ifdef CPU_RUN_CTRL_RETIRE_EN
    localparam bit RetEn = 1'b1;
`else
    localparam bit RetEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    cpu_run_ctrl_if #(.CNT_W(CntW)) bus ();

    cpu_run_ctrl #(
        .RST_CYCLES(RstCycles),
        .MAX_CYCLES(MaxCycles),
        .CNT_W     (CntW)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string ph, input bit rst, input bit en, input bit bsy,
                               input bit dn, input bit to, input longint cc, input longint rc);
        check_eq({ph, ".cpu_reset"},  bus.cpu_reset,  rst);
        check_eq({ph, ".cpu_en"},     bus.cpu_en,     en);
        check_eq({ph, ".busy"},       bus.busy,       bsy);
        check_eq({ph, ".done"},       bus.done,       dn);
        check_eq({ph, ".timeout"},    bus.timeout,    to);
        check_eq({ph, ".cycle_cnt"},  bus.cycle_cnt,  cc);
        check_eq({ph, ".retire_cnt"}, bus.retire_cnt, rc);
    endtask

    // Inputs that must have no effect in the current phase
    task automatic drive_noise(input bit with_start);
        bus.step   = 1'($urandom_range(1));
        bus.halt   = 1'($urandom_range(1));
        bus.retire = 1'($urandom_range(1));
        bus.mode   = 1'($urandom_range(1));
        bus.start  = with_start ? 1'($urandom_range(1)) : 1'b0;
    endtask

    // One run from IDLE/DONE. halt_at: enabled cycle on which the CPU halts (0 = never).
    // abort_at: cycle_cnt value at which reset is pulsed (0 = never).
    task automatic do_run(input bit m, input int halt_at, input int abort_at, input int step_pct);
        int     en_cnt = 0;
        int     ret_cnt = 0;
        bit     prev_step = 1'b0;
        bit     fin = 1'b0;
        bit     to = 1'b0;
        bit     exp_en;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.step  = 1'b0;
        bus.halt  = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= int'(RstCycles); k++) begin
            chk_outputs("rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
            drive_noise(1'b1);
            @(negedge clk);
        end
        for (int cyc = 0; !fin; cyc++) begin
            if (cyc > 5000) begin
                check_eq("run_bound", 64'(cyc), 64'd5000);
                return;
            end
            exp_en = m ? prev_step : 1'b1;
            chk_outputs("run", 1'b0, exp_en, 1'b1, 1'b0, 1'b0, en_cnt, ret_cnt);
            if (abort_at != 0 && en_cnt == abort_at) begin
                reset     = 1'b1;
                bus.start = 1'b1;
                bus.halt  = 1'b0;
                @(negedge clk);
                reset     = 1'b0;
                bus.start = 1'b0;
                chk_outputs("abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
                repeat (3) begin
                    drive_noise(1'b0);
                    @(negedge clk);
                    chk_outputs("abort_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
                end
                return;
            end
            bus.step   = ($urandom_range(99) < step_pct);
            bus.retire = 1'($urandom_range(1));
            bus.start  = 1'($urandom_range(1));
            bus.mode   = 1'($urandom_range(1));
            bus.halt   = (halt_at != 0) && exp_en && (en_cnt + 1 == halt_at);
            if (exp_en) en_cnt++;
            if (RetEn && bus.retire) ret_cnt++;
            prev_step = bus.step;
            if (bus.halt) begin
                fin = 1'b1;
                to  = 1'b0;
            end else if (exp_en && en_cnt == int'(MaxCycles)) begin
                fin = 1'b1;
                to  = 1'b1;
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            chk_outputs("done", 1'b0, 1'b0, 1'b0, 1'b1, to, en_cnt, ret_cnt);
            drive_noise(1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        bus.step   = 1'b0;
        bus.halt   = 1'b0;
        bus.retire = 1'b0;
        repeat (2) @(negedge clk);
        chk_outputs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_noise(1'b0);
            bus.retire = 1'b1;
            @(negedge clk);
            chk_outputs("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        end
        do_run(1'b0, 0, 0, 50);
        do_run(1'b0, 37, 0, 50);
        do_run(1'b1, 3, 0, 70);
        do_run(1'b0, 100, 0, 50);
        do_run(1'b0, 0, 20, 50);
        for (int r = 0; r < 8; r++) begin
            do_run(1'($urandom_range(1)), int'($urandom_range(130)), 0,
                   int'($urandom_range(90, 40)));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 4, cycles cpu_reset is held after start; legal range 1..255.
REQ-002 Parameter MAX_CYCLES, default 100, run-cycle limit before timeout; 0 disables the limit.
REQ-003 Parameter CNT_W, default 32, width of all counters.
REQ-004 clk  in  1  sole clock, all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a run.
REQ-007 mode  in  1  0 = free-run, 1 = single-step; latched on accepted start.
REQ-008 step  in  1  single-step request pulse.
REQ-009 halt  in  1  CPU end-of-program indication.
REQ-010 retire  in  1  CPU committed one instruction this cycle.
REQ-011 cpu_reset  out  1  reset to CPU core.
REQ-012 cpu_en  out  1  clock enable to CPU core.
REQ-013 cycle_cnt  out  CNT_W  enabled CPU cycles this run.
REQ-014 retire_cnt  out  CNT_W  retired instructions this run (see Configuration).
REQ-015 busy  out  1  high in RST or RUN.
REQ-016 done  out  1  run finished.
REQ-017 timeout  out  1  run finished by cycle limit.

Function
REQ-018 States IDLE, RST, RUN, DONE; all outputs registered.
REQ-019 IDLE: cpu_reset=1, cpu_en=0; start -> RST.
REQ-020 RST: counters cleared on entry, done=0, timeout=0, cpu_reset=1, cpu_en=0 for exactly RST_CYCLES cycles, then RUN.
REQ-021 RUN: cpu_reset=0; mode 0 -> cpu_en=1 every cycle.
REQ-022 RUN mode 1 -> cpu_en=1 for exactly one cycle, the cycle after step is sampled high; consecutive step cycles give consecutive enables.
REQ-023 cycle_cnt +1 per cycle with cpu_en=1; saturates at all-ones.
REQ-024 halt sampled high in RUN -> DONE next cycle, done=1, timeout=0; cpu_en=0 from DONE entry.
REQ-025 MAX_CYCLES!=0 and cycle_cnt reaches MAX_CYCLES -> DONE, done=1, timeout=1; cpu_en never exceeds MAX_CYCLES enabled cycles.
REQ-026 halt and limit in same cycle -> halt wins, timeout=0.
REQ-027 DONE: cpu_reset=0, cpu_en=0, counters and flags held; start -> RST (restart, counters cleared).
REQ-028 start in RST or RUN ignored; step ignored outside RUN or in mode 0.
REQ-029 halt and retire ignored outside RUN.

Reset
REQ-030 reset wins over all inputs: state IDLE, cpu_reset=1, cpu_en=0, busy=0, done=0, timeout=0, counters 0, latched mode 0.
REQ-031 reset mid-RST or mid-RUN aborts the run; no done pulse produced.

Configuration
REQ-032 Macro CPU_RUN_CTRL_RETIRE_EN defined: retire_cnt +1 per cycle with retire=1 in RUN, saturating, cleared in RST.
REQ-033 Macro undefined: retire_cnt constant 0, retire input unused, no counter logic.

Verification
REQ-034 Defaults, mode 0, start at cycle 2, no halt -> cpu_reset high 4 cycles, cpu_en high exactly 100 cycles, done=1, timeout=1, cycle_cnt=100.
REQ-035 Mode 0, halt after 37 enabled cycles -> done=1, timeout=0, cycle_cnt=37, cpu_en low next cycle.
REQ-036 Mode 1, 3 step pulses incl. 2 back-to-back -> exactly 3 cpu_en cycles, each one cycle after its step, cycle_cnt=3.
REQ-037 Halt on the cycle cycle_cnt reaches 100 -> timeout=0, done=1.
REQ-038 reset asserted during RUN at cycle_cnt=20 -> next cycle IDLE, cpu_reset=1, cycle_cnt=0, done=0; start while in RUN has no effect.
REQ-039 CPU_RUN_CTRL_RETIRE_EN defined, retire high 12 cycles in RUN, 2 before start -> retire_cnt=12; undefined -> retire_cnt=0.
